// File: rtl/rf_writeback_arbiter_if.sv
// Write-back bus between the result producers, the hazard unit and the
// register-file write port.
interface rf_writeback_arbiter_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        wb_stall;
  logic [31:0] pending_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, wb_stall, pending_mask, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, wb_stall, pending_mask, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Single-port register-file write-back arbiter: pipeline results have priority,
// MDU results queue in a small FIFO and force a pipeline stall when they starve.
module rf_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  rf_writeback_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]   ptr_t;
  typedef logic [AW-1:0] idx_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  localparam ptr_t       DEPTH_P   = ptr_t'(DEPTH);
  localparam logic [2:0] AGE_LIMIT = 3'(STARVE_LIMIT - 1);

  wb_entry_t   fifo_q [DEPTH];
  ptr_t        wr_ptr_q, rd_ptr_q;
  logic [2:0]  age_q;
  logic        stall_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  ptr_t        count, count_next;
  logic        full, empty, push, pop;
  logic        grant_fifo, grant_pipe, grant_valid;
  logic [4:0]  grant_rd;
  logic [31:0] grant_data;
  logic [2:0]  age_next;
  logic        stall_next;
  logic [31:0] mask;
  wb_entry_t   head;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_P);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = fifo_q[rd_ptr_q[AW-1:0]];

  // ready depends on occupancy only, so the MDU never sees a combinational loop
  assign push = bus.mdu_valid && !full;

  // Rule order: forced head grant, then pipeline, then opportunistic head grant.
  assign grant_fifo  = !empty && (stall_q || !bus.pipe_valid);
  assign grant_pipe  = bus.pipe_valid && !grant_fifo;
  assign grant_valid = grant_fifo || grant_pipe;
  assign grant_rd    = grant_fifo ? head.rd   : bus.pipe_rd;
  assign grant_data  = grant_fifo ? head.data : bus.pipe_data;
  assign pop         = grant_fifo;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_next = count + ptr_t'(push) - ptr_t'(pop);
    age_next   = '0;
    if (!empty && !pop)
      age_next = (age_q == 3'b111) ? age_q : age_q + 3'd1;
    stall_next = ((age_next >= AGE_LIMIT) && !pop) || (count_next == DEPTH_P);
  end

  // Slot i is live when its distance from the read pointer is below occupancy.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_t'(idx_t'(i) - rd_ptr_q[AW-1:0]) < count)
        mask[fifo_q[i].rd] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  // NOTE: payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q[AW-1:0]] <= '{rd: bus.mdu_rd, data: bus.mdu_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      age_q      <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      age_q   <= age_next;
      stall_q <= stall_next;
      // x0 writes are consumed but never reach the register file
      rf_we_q <= grant_valid && (grant_rd != 5'd0);
      if (grant_valid) begin
        rf_waddr_q <= grant_rd;
        rf_wdata_q <= grant_data;
      end
    end
  end

  assign bus.mdu_ready    = !full;
  assign bus.wb_stall     = stall_q;
  assign bus.pending_mask = mask;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: per-cycle vector table plus directed reset
// and starvation sequences, with a write-order scoreboard on the RF port.
module tb_rf_writeback_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_writeback_arbiter_if bus ();

  rf_writeback_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        we;
    logic        chk_addr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready;
    logic        stall;
    logic [31:0] mask;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then retire any RF write
  // against the scoreboard.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wr_t e;
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pd;
    bus.mdu_valid  = mv;
    bus.mdu_rd     = mrd;
    bus.mdu_data   = md;
    @(posedge clk);
    #1;
    if (bus.rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_write", 32'(bus.rf_we), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_waddr", 32'(bus.rf_waddr), 32'(e.rd));
        check("sb_wdata", bus.rf_wdata, e.data);
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic we, logic ca, logic [4:0] wa, logic [31:0] wd,
                              logic rdy, logic st, logic [31:0] msk);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.we = we; v.chk_addr = ca; v.waddr = wa; v.wdata = wd;
    v.ready = rdy; v.stall = st; v.mask = msk;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic saw_stall;
    logic pv_d;

    //               pv  prd    pd            mv  mrd    md            we  ca  waddr  wdata         rdy st  mask
    tbl[0]  = mk(1, 5'd5,  32'h1234, 0, 5'd0,  32'h0,     1, 1, 5'd5,  32'h1234, 1, 0, 32'h0);
    tbl[1]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 1, 5'd5,  32'h1234, 1, 0, 32'h0);
    tbl[2]  = mk(1, 5'd3,  32'hA,    1, 5'd7,  32'hB,     1, 1, 5'd3,  32'hA,    1, 0, 32'h80);
    tbl[3]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     1, 1, 5'd7,  32'hB,    1, 0, 32'h0);
    tbl[4]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 1, 5'd7,  32'hB,    1, 0, 32'h0);
    tbl[5]  = mk(0, 5'd0,  32'h0,    1, 5'd0,  32'hFFFF,  0, 1, 5'd7,  32'hB,    1, 0, 32'h0);
    tbl[6]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 0, 5'd0,  32'h0,    1, 0, 32'h0);
    tbl[7]  = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 0, 5'd0,  32'h0,    1, 0, 32'h0);
    tbl[8]  = mk(1, 5'd1,  32'h100,  1, 5'd9,  32'h900,   1, 1, 5'd1,  32'h100,  1, 0, 32'h200);
    tbl[9]  = mk(1, 5'd2,  32'h200,  1, 5'd10, 32'hA00,   1, 1, 5'd2,  32'h200,  0, 1, 32'h600);
    tbl[10] = mk(0, 5'd0,  32'h0,    1, 5'd11, 32'hB00,   1, 1, 5'd9,  32'h900,  1, 0, 32'h400);
    tbl[11] = mk(0, 5'd0,  32'h0,    1, 5'd11, 32'hB00,   1, 1, 5'd10, 32'hA00,  1, 0, 32'h800);
    tbl[12] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     1, 1, 5'd11, 32'hB00,  1, 0, 32'h0);
    tbl[13] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 1, 5'd11, 32'hB00,  1, 0, 32'h0);
    tbl[14] = mk(1, 5'd0,  32'hDEAD, 0, 5'd0,  32'h0,     0, 0, 5'd0,  32'h0,    1, 0, 32'h0);
    tbl[15] = mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,     0, 0, 5'd0,  32'h0,    1, 0, 32'h0);

    // Power-on reset
    rst = 1'b1;
    idle();
    idle();
    check("rst_we",    32'(bus.rf_we),     32'd0);
    check("rst_waddr", 32'(bus.rf_waddr),  32'd0);
    check("rst_wdata", bus.rf_wdata,       32'd0);
    check("rst_stall", 32'(bus.wb_stall),  32'd0);
    check("rst_mask",  bus.pending_mask,   32'd0);
    check("rst_ready", 32'(bus.mdu_ready), 32'd1);
    rst = 1'b0;

    // Per-cycle vectors: outputs observed after the edge that consumed the row
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].we)
        sb_q.push_back('{rd: tbl[i].waddr, data: tbl[i].wdata});
      step(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      check($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].we));
      if (tbl[i].chk_addr) begin
        check($sformatf("v%0d_waddr", i), 32'(bus.rf_waddr), 32'(tbl[i].waddr));
        check($sformatf("v%0d_wdata", i), bus.rf_wdata, tbl[i].wdata);
      end
      check($sformatf("v%0d_ready", i), 32'(bus.mdu_ready), 32'(tbl[i].ready));
      check($sformatf("v%0d_stall", i), 32'(bus.wb_stall),  32'(tbl[i].stall));
      check($sformatf("v%0d_mask", i),  bus.pending_mask,   tbl[i].mask);
    end

    // Starvation: upstream keeps issuing until told to stall
    lat       = -1;
    saw_stall = 1'b0;
    sb_q.push_back('{rd: 5'd4, data: 32'h40});
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd12, 32'hC00);
    check("starve_mask", bus.pending_mask, 32'h1000);
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      pv_d = !bus.wb_stall;
      if (pv_d) begin
        sb_q.push_back('{rd: 5'd4, data: 32'h40 + 32'(k)});
      end else begin
        saw_stall = 1'b1;
        sb_q.push_back('{rd: 5'd12, data: 32'hC00});
      end
      step(pv_d, 5'd4, 32'h40 + 32'(k), 1'b0, 5'd0, 32'd0);
      if (bus.rf_we === 1'b1 && bus.rf_waddr == 5'd12)
        lat = k;
    end
    check("starve_stall_seen", 32'(saw_stall), 32'd1);
    check("starve_latency_ok", 32'(lat >= 1 && lat <= STARVE_LIMIT + 1), 32'd1);
    idle();
    check("starve_stall_clear", 32'(bus.wb_stall), 32'd0);
    check("starve_mask_clear",  bus.pending_mask,  32'd0);

    // Reset with two buffered MDU results: they must never be written
    sb_q.push_back('{rd: 5'd1, data: 32'h111});
    step(1'b1, 5'd1, 32'h111, 1'b1, 5'd20, 32'h1400);
    sb_q.push_back('{rd: 5'd2, data: 32'h222});
    step(1'b1, 5'd2, 32'h222, 1'b1, 5'd21, 32'h1500);
    check("pre_rst_mask",  bus.pending_mask,   32'h0030_0000);
    check("pre_rst_ready", 32'(bus.mdu_ready), 32'd0);
    check("pre_rst_stall", 32'(bus.wb_stall),  32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mid_rst_we",    32'(bus.rf_we),     32'd0);
    check("mid_rst_waddr", 32'(bus.rf_waddr),  32'd0);
    check("mid_rst_wdata", bus.rf_wdata,       32'd0);
    check("mid_rst_mask",  bus.pending_mask,   32'd0);
    check("mid_rst_ready", 32'(bus.mdu_ready), 32'd1);
    check("mid_rst_stall", 32'(bus.wb_stall),  32'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check($sformatf("post_rst_we%0d", k), 32'(bus.rf_we), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
